// File: rtl/ysyx_23060191_imem_pkg.sv
// rtl/ysyx_23060191_imem_pkg.sv - shared width, base address and FSM state encoding for the imem
package ysyx_23060191_imem_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [CPU_WIDTH-1:0] BASE_ADDR_DEF = 32'h8000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/ysyx_23060191_imem_if.sv
// rtl/ysyx_23060191_imem_if.sv - fetch request/response and preload bundle between IFU and imem
//
// Signals:
//   req_valid/req_ready/req_addr       fetch request (byte address)
//   rsp_valid/rsp_ready/rsp_data/err   fetch response, data is 0 on a fault
//   ld_en/ld_idx/ld_data               preload word write
// Modports: master = IFU/loader side, slave = imem side.
interface ysyx_23060191_imem_if #(
    parameter int W  = 32,
    parameter int IW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          ld_en;
    logic [IW-1:0] ld_idx;
    logic [W-1:0]  ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_idx, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_idx, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ysyx_23060191_imem_array.sv
// rtl/ysyx_23060191_imem_array.sv - DEPTH x WIDTH word storage, one write port, one async read port
//
// Ports:
//   clk    clock for the write port
//   we     write strobe
//   waddr  write word index
//   wdata  write word
//   raddr  read word index
//   rdata  read word (combinational)
// Contents are deliberately not reset so programs survive a core reset.
module ysyx_23060191_imem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_23060191_imem.sv
// rtl/ysyx_23060191_imem.sv - handshaked instruction memory with preload port and fetch fault flag
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  slave side of ysyx_23060191_imem_if (request, response, preload)
// Parameters: DEPTH words (power of two), BASE_ADDR of word 0 (word-aligned),
// LATENCY 1..15 cycles from accept to rsp_valid.
module ysyx_23060191_imem
    import ysyx_23060191_imem_pkg::*;
#(
    parameter int                   DEPTH     = 256,
    parameter logic [CPU_WIDTH-1:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int                   LATENCY   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_23060191_imem_if.slave    bus
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
    localparam state_t     ACC_NEXT = (LATENCY > 1) ? S_WAIT : S_RESP;

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             cnt;
    logic [CPU_WIDTH-1:0]   rsp_data_q;
    logic                   rsp_err_q;

    logic [CPU_WIDTH-1:0]   off;
    logic [CPU_WIDTH-1:0]   rd_data;
    logic [IDX_W-1:0]       rd_idx;
    logic                   fault;
    logic                   accept;

    // Wrapping offset from the base; an address below the base wraps to a
    // huge offset but is also caught explicitly by the compare.
    assign off = bus.req_addr - BASE_ADDR;

    // With a word-aligned base the low offset bits equal the low address bits.
    assign fault = (off[1:0] != 2'b00)
                || (bus.req_addr < BASE_ADDR)
                || (off[CPU_WIDTH-1:IDX_W+2] != '0);

    assign rd_idx = off[IDX_W+1:2];

    ysyx_23060191_imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (CPU_WIDTH),
        .AW    (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (bus.ld_en),
        .waddr (bus.ld_idx),
        .wdata (bus.ld_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // Ready and valid depend only on state and rsp_ready.
    assign bus.req_ready = (state == S_IDLE) || ((state == S_RESP) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_next = ACC_NEXT;
                end else if ((state == S_RESP) && bus.rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = S_RESP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The array is read combinationally at accept, so a same-cycle preload
    // to the same index lands after the capture (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt        <= LAT_M1;
                rsp_data_q <= fault ? '0 : rd_data;
                rsp_err_q  <= fault;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_imem.sv
// tb/tb_ysyx_23060191_imem.sv - self-checking bench for ysyx_23060191_imem (LATENCY 1 and 3 instances)
module tb_ysyx_23060191_imem;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [2];
    logic        rv    [2];
    logic [31:0] ra    [2];
    logic        rr    [2];
    logic        le    [2];
    logic [7:0]  li    [2];
    logic [31:0] ld    [2];
    logic        rdy   [2];
    logic        vld   [2];
    logic        er    [2];
    logic [31:0] dat   [2];

    ysyx_23060191_imem_if #(.W(32), .IW(8)) bus [2] ();

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gen_dut
            assign bus[g].req_valid = rv[g];
            assign bus[g].req_addr  = ra[g];
            assign bus[g].rsp_ready = rr[g];
            assign bus[g].ld_en     = le[g];
            assign bus[g].ld_idx    = li[g];
            assign bus[g].ld_data   = ld[g];
            assign rdy[g]           = bus[g].req_ready;
            assign vld[g]           = bus[g].rsp_valid;
            assign er[g]            = bus[g].rsp_err;
            assign dat[g]           = bus[g].rsp_data;

            ysyx_23060191_imem #(
                .DEPTH     (DEPTH),
                .BASE_ADDR (BASE),
                .LATENCY   ((g == 0) ? 1 : 3)
            ) dut (
                .clk (clk),
                .rst (rst_v[g]),
                .bus (bus[g])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void tmo(string nm);
        total++;
        bad++;
        $display("FAIL timeout %s: no handshake within 50 cycles", nm);
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [2][DEPTH];
    bit          have  [2];
    logic [31:0] md    [2];
    bit          me    [2];
    int          rdy_at[2];
    int          cyc    = 0;
    bit          chk_en = 0;

    function automatic bit is_fault(logic [31:0] a);
        longint unsigned ua = a;
        longint unsigned ub = BASE;
        if ((ua % 4) != 0) return 1'b1;
        if (ua < ub) return 1'b1;
        if (((ua - ub) / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Expected outputs come from "is there a pending response and has its
    // latency elapsed"; the model then advances by what the coming edge does.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                bit ev;
                bit erd;
                bit f;
                int idx;
                ev  = have[d] && (cyc >= rdy_at[d]);
                erd = !have[d] || (ev && rr[d]);
                chk($sformatf("d%0d rsp_valid cyc%0d", d, cyc), {31'd0, vld[d]}, {31'd0, ev});
                chk($sformatf("d%0d req_ready cyc%0d", d, cyc), {31'd0, rdy[d]}, {31'd0, erd});
                if (ev) begin
                    chk($sformatf("d%0d rsp_data cyc%0d", d, cyc), dat[d], md[d]);
                    chk($sformatf("d%0d rsp_err cyc%0d", d, cyc), {31'd0, er[d]}, {31'd0, me[d]});
                end
                if (rst_v[d]) begin
                    have[d] = 1'b0;
                end else begin
                    if (ev && rr[d]) have[d] = 1'b0;
                    if (rv[d] && erd) begin
                        f = is_fault(ra[d]);
                        if (f) begin
                            md[d] = 32'd0;
                        end else begin
                            idx   = int'((ra[d] - BASE) >> 2);
                            md[d] = mem_m[d][idx];
                        end
                        me[d]     = f;
                        have[d]   = 1'b1;
                        rdy_at[d] = cyc + ((d == 0) ? 1 : 3);
                    end
                end
                if (le[d]) mem_m[d][li[d]] = ld[d];
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic fetch(input int d, input logic [31:0] a,
                         output logic [31:0] data, output logic err, output int lat);
        int n;
        @(negedge clk);
        rv[d] = 1'b1; ra[d] = a; rr[d] = 1'b1;
        #1; n = 0;
        while (!rdy[d] && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) tmo("fetch accept");
        @(negedge clk);
        rv[d] = 1'b0;
        #1; n = 0;
        while (!vld[d] && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) tmo("fetch response");
        data = dat[d];
        err  = er[d];
        lat  = n + 1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (r == 7) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        else if (r == 8) return BASE - 32'(4 * $urandom_range(1, 16));
        else             return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
    endfunction

    logic [31:0] prog [5];
    logic [31:0] rd;
    logic        re;
    int          lt;

    initial begin
        prog[0] = 32'h00100913; prog[1] = 32'h00200993; prog[2] = 32'h00400a13;
        prog[3] = 32'h00800a93; prog[4] = 32'h00490b13;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; rv[d] = 1'b0; ra[d] = '0; rr[d] = 1'b1;
            le[d] = 1'b0; li[d] = '0; ld[d] = '0;
            have[d] = 1'b0; md[d] = '0; me[d] = 1'b0; rdy_at[d] = 0;
        end

        // reset state
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        chk_en = 1'b1;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset rsp_valid", d), {31'd0, vld[d]}, 32'd0);
            chk($sformatf("d%0d reset rsp_data", d), dat[d], 32'd0);
            chk($sformatf("d%0d reset rsp_err", d), {31'd0, er[d]}, 32'd0);
            chk($sformatf("d%0d reset req_ready", d), {31'd0, rdy[d]}, 32'd1);
        end

        // preload: program words then random fill
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            @(negedge clk);
            w = (i < 5) ? prog[i] : $urandom;
            for (int d = 0; d < 2; d++) begin le[d] = 1'b1; li[d] = 8'(i); ld[d] = w; end
        end
        @(negedge clk);
        le[0] = 1'b0; le[1] = 1'b0;

        // LATENCY=1 back-to-back fetch of the five program words
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rr[0] = 1'b1;
            rv[0] = (i < 5);
            ra[0] = BASE + 32'(4 * i);
            #3;
            if (i < 5) chk($sformatf("b2b req_ready %0d", i), {31'd0, rdy[0]}, 32'd1);
            if (i > 0) begin
                chk($sformatf("b2b rsp_valid %0d", i - 1), {31'd0, vld[0]}, 32'd1);
                chk($sformatf("b2b rsp_data %0d", i - 1), dat[0], prog[i-1]);
                chk($sformatf("b2b rsp_err %0d", i - 1), {31'd0, er[0]}, 32'd0);
            end
        end

        // LATENCY=3 single fetch
        fetch(1, BASE + 32'h4, rd, re, lt);
        chk("lat3 latency", 32'(lt), 32'd3);
        chk("lat3 data", rd, 32'h00200993);

        // backpressure while overwriting the same word
        @(negedge clk);
        rv[1] = 1'b1; ra[1] = BASE + 32'h4; rr[1] = 1'b0;
        @(negedge clk);
        rv[1] = 1'b0;
        begin
            int n = 0;
            #1;
            while (!vld[1] && n < 50) begin @(negedge clk); #1; n++; end
            if (n >= 50) tmo("backpressure response");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            le[1] = (i == 0); li[1] = 8'd1; ld[1] = 32'hDEADBEEF;
            #3;
            chk($sformatf("bp data %0d", i), dat[1], 32'h00200993);
            chk($sformatf("bp req_ready %0d", i), {31'd0, rdy[1]}, 32'd0);
        end
        @(negedge clk);
        le[1] = 1'b0;
        fetch(1, BASE + 32'h4, rd, re, lt);
        chk("bp refetch", rd, 32'hDEADBEEF);

        // faults on the LATENCY=1 instance
        fetch(0, 32'h8000_0002, rd, re, lt);
        chk("misaligned err", {31'd0, re}, 32'd1);
        chk("misaligned data", rd, 32'd0);
        fetch(0, 32'h7FFF_FFFC, rd, re, lt);
        chk("below err", {31'd0, re}, 32'd1);
        chk("below data", rd, 32'd0);
        fetch(0, 32'h8000_0400, rd, re, lt);
        chk("above err", {31'd0, re}, 32'd1);
        chk("above data", rd, 32'd0);
        fetch(0, 32'h8000_03FC, rd, re, lt);
        chk("last word err", {31'd0, re}, 32'd0);
        chk("last word data", rd, mem_m[0][255]);

        // same-cycle preload and accept to the same index
        @(negedge clk);
        rv[0] = 1'b1; ra[0] = BASE + 32'h8; rr[0] = 1'b1;
        le[0] = 1'b1; li[0] = 8'd2; ld[0] = 32'h12345678;
        #1;
        chk("collision req_ready", {31'd0, rdy[0]}, 32'd1);
        @(negedge clk);
        rv[0] = 1'b0; le[0] = 1'b0;
        #1;
        chk("collision valid", {31'd0, vld[0]}, 32'd1);
        chk("collision old word", dat[0], 32'h00400a13);
        fetch(0, BASE + 32'h8, rd, re, lt);
        chk("collision new word", rd, 32'h12345678);

        // reset while in WAIT
        @(negedge clk);
        rv[1] = 1'b1; ra[1] = BASE; rr[1] = 1'b1;
        @(negedge clk);
        rv[1] = 1'b0; rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        #3;
        chk("rst wait valid", {31'd0, vld[1]}, 32'd0);
        chk("rst wait data", dat[1], 32'd0);
        chk("rst wait err", {31'd0, er[1]}, 32'd0);
        chk("rst wait ready", {31'd0, rdy[1]}, 32'd1);

        // reset while in RESP
        @(negedge clk);
        rv[1] = 1'b1; ra[1] = BASE + 32'h10; rr[1] = 1'b0;
        @(negedge clk);
        rv[1] = 1'b0;
        begin
            int n = 0;
            #1;
            while (!vld[1] && n < 50) begin @(negedge clk); #1; n++; end
            if (n >= 50) tmo("rst resp response");
        end
        @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0; rr[1] = 1'b1;
        #3;
        chk("rst resp valid", {31'd0, vld[1]}, 32'd0);
        chk("rst resp data", dat[1], 32'd0);
        chk("rst resp err", {31'd0, er[1]}, 32'd0);
        chk("rst resp ready", {31'd0, rdy[1]}, 32'd1);
        fetch(1, BASE, rd, re, lt);
        chk("intact idx0", rd, 32'h00100913);
        fetch(1, BASE + 32'h10, rd, re, lt);
        chk("intact idx4", rd, 32'h00490b13);

        // randomized traffic on both instances
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rv[d] = 1'($urandom_range(0, 1));
                ra[d] = rand_addr();
                rr[d] = ($urandom_range(0, 3) != 0);
                le[d] = ($urandom_range(0, 3) == 0);
                li[d] = 8'($urandom);
                ld[d] = $urandom;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin rv[d] = 1'b0; rr[d] = 1'b1; le[d] = 1'b0; end
        repeat (10) @(negedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_imem.md
# ysyx_23060191_imem

Parametrised, handshaked instruction memory for the NPC fetch path. It replaces the fixed five-entry combinational program ROM. Key properties:
- configurable depth, base address and read latency;
- a preload write port for loading programs;
- a valid/ready request/response protocol toward the IFU;
- an error flag for misaligned or out-of-range fetch addresses.

## Interface
- `CPU_WIDTH`, default 32: address and instruction width (taken from the shared defines).
- `DEPTH`, default 256: number of 32-bit words; a power of two ≥ 2.
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `LATENCY`, default 1: cycles from request accept to `rsp_valid`; legal range 1..15.
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  IFU presents a fetch address.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_addr`  in  CPU_WIDTH  byte address of the instruction (PC).
- `rsp_valid`  out  1  response data and error flag are valid.
- `rsp_ready`  in  1  IFU consumes the response.
- `rsp_data`  out  CPU_WIDTH  fetched instruction; 0 when `rsp_err` is set.
- `rsp_err`  out  1  fetch fault (misaligned address or address outside the array).
- `ld_en`  in  1  preload write strobe.
- `ld_idx`  in  $clog2(DEPTH)  word index to write.
- `ld_data`  in  CPU_WIDTH  word to write.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, latency counter=0. Array contents are not reset.
- Ready rule: `req_ready` = (state==IDLE) || (state==RESP && `rsp_ready`).
- Accept: a request is accepted when `req_valid && req_ready`.
- Address decode at accept: `off` = `req_addr` − `BASE_ADDR`, computed at CPU_WIDTH bits and wrapping.
  - Fault if `req_addr[1:0]`≠0, or `req_addr` < `BASE_ADDR`, or `off[CPU_WIDTH-1:2]` ≥ DEPTH.
  - Otherwise the word index is `off[$clog2(DEPTH)+1:2]`.
- Capture at accept:
  - the array word is read into a response register, or 0 on a fault;
  - the fault flag is latched;
  - the counter is loaded with LATENCY−1.
- Transitions out of IDLE and RESP (both use the same rules):
  - on an accept: go to WAIT if LATENCY>1, else go to RESP;
  - in RESP, a `rsp_ready` handshake with no new request: go to IDLE;
  - otherwise: stay.
- WAIT: the counter decrements each cycle. When the counter equals 1 (decrementing to 0), go to RESP.
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_err` are held stable until `rsp_ready`. While waiting for `rsp_ready`, the response is never dropped and never changes.
- Preload: when `ld_en` is high, `ld_data` is written to `ld_idx` at the edge. The port is always available, in every state.
- Write/read collisions:
  - A load in the same cycle as an accept to the same index: the response returns the old word (read-before-write).
  - Loads issued while a request is pending do not alter the captured response.
- Reset mid-operation: the FSM returns to IDLE, and any pending or presented response is discarded.

## Timing
- Accept at edge t: `rsp_valid` rises after edge t+LATENCY−1 (visible in cycle t+LATENCY).
- With LATENCY=1: one request per cycle is sustained when `rsp_ready` is held high (back-to-back via RESP→RESP).
- With LATENCY>1: throughput is one fetch per LATENCY cycles. `req_ready`=0 throughout WAIT.
- A written word is readable by a request accepted in the cycle after the write edge.
- `req_ready` and `rsp_valid` depend on state and `rsp_ready` only. There is no combinational path from `req_valid` or `req_addr` to any output.

## Structure
- Shared defines hold: `CPU_WIDTH`, the default `BASE_ADDR` constant, and the 2-bit state encoding localparams (IDLE=0, WAIT=1, RESP=2).
- Sub-module `ysyx_23060191_imem_array`: DEPTH×CPU_WIDTH storage with one write port and one asynchronous read port, with no reset.
- The FSM, address decode, counter and response registers live in the top module.

## Test plan
- Reset, then preload idx0..4 with 32'h00100913, 32'h00200993, 32'h00400a13, 32'h00800a93, 32'h00490b13. Fetch 0x8000_0000..0x8000_0010 with LATENCY=1 and `rsp_ready`=1 → five consecutive responses of those words, `rsp_err`=0, one per cycle.
- LATENCY=3: fetch 0x8000_0004 → `req_ready` low for 2 cycles; `rsp_valid` appears 3 cycles after accept with 32'h00200993.
- Backpressure: hold `rsp_ready`=0 for 4 cycles in RESP while writing idx1=32'hDEADBEEF → `rsp_data` stays 32'h00200993 and `req_ready`=0. After release, a refetch of 0x8000_0004 returns 32'hDEADBEEF.
- Faults: addresses 0x8000_0002, 0x7FFF_FFFC and 0x8000_0400 (DEPTH=256) → `rsp_err`=1, `rsp_data`=0. Address 0x8000_03FC → `rsp_err`=0.
- Collision: accept 0x8000_0008 in the same cycle as `ld_en` to idx2 with 32'h12345678 → response 32'h00400a13; the next fetch of the same address returns 32'h12345678.
- Assert `rst` in WAIT and in RESP → the next cycle shows `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `req_ready`=1, and preloaded words are still intact.
